// File: rtl/l2_mem_obi_bridge_if.sv
// l2_mem_obi_bridge_if: L2 line request/response and OBI bus bundle; slave = bridge view, master = L2/memory view
interface l2_mem_obi_bridge_if #(
  parameter int LINE_WIDTH      = 128,
  parameter int LINE_ADDR_WIDTH = 28,
  parameter int TAG_WIDTH       = 8
);
  logic                       mem_req_valid_i;
  logic                       mem_req_rw_i;
  logic [LINE_WIDTH/8-1:0]    mem_req_byteen_i;
  logic [LINE_ADDR_WIDTH-1:0] mem_req_addr_i;
  logic [LINE_WIDTH-1:0]      mem_req_data_i;
  logic [TAG_WIDTH-1:0]       mem_req_tag_i;
  logic                       mem_req_ready_o;
  logic                       mem_rsp_valid_o;
  logic [LINE_WIDTH-1:0]      mem_rsp_data_o;
  logic [TAG_WIDTH-1:0]       mem_rsp_tag_o;
  logic                       mem_rsp_ready_i;
  logic                       obi_req_o;
  logic                       obi_gnt_i;
  logic [31:0]                obi_addr_o;
  logic                       obi_we_o;
  logic [3:0]                 obi_be_o;
  logic [31:0]                obi_wdata_o;
  logic                       obi_rvalid_i;
  logic [31:0]                obi_rdata_i;
  modport slave (
    input  mem_req_valid_i, mem_req_rw_i, mem_req_byteen_i, mem_req_addr_i, mem_req_data_i, mem_req_tag_i,
    output mem_req_ready_o, mem_rsp_valid_o, mem_rsp_data_o, mem_rsp_tag_o,
    input  mem_rsp_ready_i,
    output obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
    input  obi_gnt_i, obi_rvalid_i, obi_rdata_i
  );
  modport master (
    output mem_req_valid_i, mem_req_rw_i, mem_req_byteen_i, mem_req_addr_i, mem_req_data_i, mem_req_tag_i,
    input  mem_req_ready_o, mem_rsp_valid_o, mem_rsp_data_o, mem_rsp_tag_o,
    output mem_rsp_ready_i,
    input  obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
    output obi_gnt_i, obi_rvalid_i, obi_rdata_i
  );
endinterface

// File: rtl/l2_mem_obi_bridge.sv
// l2_mem_obi_bridge: serialises L2 line reads/write-backs into single-word OBI beats; ports clk_i, rst_ni (sync active-low), bus (l2_mem_obi_bridge_if.slave)
module l2_mem_obi_bridge #(
  parameter int LINE_WIDTH      = 128,
  parameter int LINE_ADDR_WIDTH = 28,
  parameter int TAG_WIDTH       = 8
) (
  input logic                clk_i,
  input logic                rst_ni,
  l2_mem_obi_bridge_if.slave bus
);
  localparam int NW  = LINE_WIDTH / 32;
  localparam int BW  = LINE_WIDTH / 8;
  localparam int OFF = $clog2(BW);
  localparam int CW  = NW > 1 ? $clog2(NW) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESP} state_t;
  state_t                state_q, state_d;
  logic                  rw_q, rw_d;
  logic [31:0]           base_q, base_d;
  logic [LINE_WIDTH-1:0] data_q, data_d, line_q, line_d;
  logic [BW-1:0]         be_q, be_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [CW-1:0]         k_q, k_d;
  logic                  ready_q, ready_d, rsp_valid_q, rsp_valid_d;
  logic                  obi_req_q, obi_req_d, obi_we_q, obi_we_d;
  logic [31:0]           obi_addr_q, obi_addr_d, obi_wdata_q, obi_wdata_d;
  logic [3:0]            obi_be_q, obi_be_d;
  logic [LINE_ADDR_WIDTH+OFF-1:0] req_byte_addr;
  logic [31:0]           req_base, cur_base;
  logic                  cur_rw, found, ld;
  logic [BW-1:0]         cur_be, eff_be;
  logic [LINE_WIDTH-1:0] cur_data;
  logic [CW-1:0]         nxt;
  int                    from;
  assign req_byte_addr = {bus.mem_req_addr_i, {OFF{1'b0}}};
  assign req_base      = 32'(req_byte_addr);
  assign cur_rw        = state_q == IDLE ? bus.mem_req_rw_i : rw_q;
  assign cur_be        = state_q == IDLE ? bus.mem_req_byteen_i : be_q;
  assign cur_data      = state_q == IDLE ? bus.mem_req_data_i : data_q;
  assign cur_base      = state_q == IDLE ? req_base : base_q;
  assign eff_be        = cur_rw ? cur_be : '1;
  assign from          = state_q == IDLE ? -1 : int'(k_q);
  always_comb begin
    found = 1'b0;
    nxt   = '0;
    for (int j = NW - 1; j >= 0; j--)
      if (j > from && |eff_be[4*j +: 4]) begin
        found = 1'b1;
        nxt   = CW'(j);
      end
  end
  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    base_d      = base_q;
    data_d      = data_q;
    be_d        = be_q;
    tag_d       = tag_q;
    k_d         = k_q;
    line_d      = line_q;
    ready_d     = ready_q;
    rsp_valid_d = rsp_valid_q;
    obi_req_d   = obi_req_q;
    obi_we_d    = obi_we_q;
    obi_addr_d  = obi_addr_q;
    obi_wdata_d = obi_wdata_q;
    obi_be_d    = obi_be_q;
    ld          = 1'b0;
    case (state_q)
      IDLE: if (bus.mem_req_valid_i) begin
        rw_d   = bus.mem_req_rw_i;
        base_d = req_base;
        data_d = bus.mem_req_data_i;
        be_d   = bus.mem_req_byteen_i;
        tag_d  = bus.mem_req_tag_i;
        if (found) begin
          state_d = ISSUE;
          ready_d = 1'b0;
          ld      = 1'b1;
        end
      end
      ISSUE: if (bus.obi_gnt_i) begin
        state_d   = WAIT_RSP;
        obi_req_d = 1'b0;
      end
      WAIT_RSP: if (bus.obi_rvalid_i) begin
        if (!rw_q) line_d[32*k_q +: 32] = bus.obi_rdata_i;
        if (found) begin
          state_d = ISSUE;
          ld      = 1'b1;
        end else begin
          state_d     = rw_q ? IDLE : RESP;
          ready_d     = rw_q;
          rsp_valid_d = !rw_q;
        end
      end
      default: if (bus.mem_rsp_ready_i) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        ready_d     = 1'b1;
      end
    endcase
    if (ld) begin
      k_d         = nxt;
      obi_req_d   = 1'b1;
      obi_we_d    = cur_rw;
      obi_addr_d  = cur_base + (32'(nxt) << 2);
      obi_be_d    = cur_rw ? cur_be[4*nxt +: 4] : 4'hF;
      obi_wdata_d = cur_data[32*nxt +: 32];
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rw_q        <= 1'b0;
      base_q      <= '0;
      data_q      <= '0;
      be_q        <= '0;
      tag_q       <= '0;
      k_q         <= '0;
      line_q      <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      obi_req_q   <= 1'b0;
      obi_we_q    <= 1'b0;
      obi_addr_q  <= '0;
      obi_wdata_q <= '0;
      obi_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      base_q      <= base_d;
      data_q      <= data_d;
      be_q        <= be_d;
      tag_q       <= tag_d;
      k_q         <= k_d;
      line_q      <= line_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      obi_req_q   <= obi_req_d;
      obi_we_q    <= obi_we_d;
      obi_addr_q  <= obi_addr_d;
      obi_wdata_q <= obi_wdata_d;
      obi_be_q    <= obi_be_d;
    end
  end
  assign bus.mem_req_ready_o = ready_q;
  assign bus.mem_rsp_valid_o = rsp_valid_q;
  assign bus.mem_rsp_data_o  = line_q;
  assign bus.mem_rsp_tag_o   = tag_q;
  assign bus.obi_req_o       = obi_req_q;
  assign bus.obi_addr_o      = obi_addr_q;
  assign bus.obi_we_o        = obi_we_q;
  assign bus.obi_be_o        = obi_be_q;
  assign bus.obi_wdata_o     = obi_wdata_q;
endmodule

// File: tb/tb_l2_mem_obi_bridge.sv
// tb_l2_mem_obi_bridge: directed self-checking bench for l2_mem_obi_bridge
module tb_l2_mem_obi_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int ncmp = 0;
  int nerr = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  l2_mem_obi_bridge_if bus ();
  l2_mem_obi_bridge dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic beat(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd,
                      input logic [31:0] rd, input int gd);
    chk("obi_req", bus.obi_req_o, 1);
    chk("obi_addr", bus.obi_addr_o, a);
    chk("obi_we", bus.obi_we_o, we);
    chk("obi_be", bus.obi_be_o, be);
    chk("obi_wdata", bus.obi_wdata_o, wd);
    repeat (gd) begin
      step();
      chk("stall_req", bus.obi_req_o, 1);
      chk("stall_addr", bus.obi_addr_o, a);
      chk("stall_wdata", bus.obi_wdata_o, wd);
    end
    bus.obi_gnt_i = 1'b1;
    step();
    bus.obi_gnt_i = 1'b0;
    chk("req_after_gnt", bus.obi_req_o, 0);
    bus.obi_rvalid_i = 1'b1;
    bus.obi_rdata_i  = rd;
    step();
    bus.obi_rvalid_i = 1'b0;
    bus.obi_rdata_i  = 32'h0;
  endtask
  task automatic do_read(input logic [27:0] la, input logic [7:0] tg, input logic [127:0] line,
                         input int gd, input int hold, input bit spur);
    int c0;
    logic [31:0] base;
    base = {la, 4'h0};
    bus.mem_req_valid_i  = 1'b1;
    bus.mem_req_rw_i     = 1'b0;
    bus.mem_req_addr_i   = la;
    bus.mem_req_tag_i    = tg;
    bus.mem_req_data_i   = '0;
    bus.mem_req_byteen_i = '0;
    chk("rd_ready_idle", bus.mem_req_ready_o, 1);
    c0 = cyc;
    step();
    bus.mem_req_valid_i = 1'b0;
    chk("rd_ready_busy", bus.mem_req_ready_o, 0);
    if (spur) begin
      bus.obi_rvalid_i = 1'b1;
      bus.obi_rdata_i  = 32'hBAD0BAD0;
      step();
      bus.obi_rvalid_i = 1'b0;
      bus.obi_rdata_i  = 32'h0;
      chk("spur_issue_req", bus.obi_req_o, 1);
      chk("spur_issue_addr", bus.obi_addr_o, base);
    end
    for (int i = 0; i < 4; i++) beat(base + 32'(4 * i), 1'b0, 4'hF, 32'h0, line[32*i +: 32], i == 0 ? gd : 0);
    chk("rsp_valid", bus.mem_rsp_valid_o, 1);
    if (gd == 0 && !spur) chk("rsp_latency", 128'(cyc - c0), 9);
    repeat (hold) begin
      chk("hold_valid", bus.mem_rsp_valid_o, 1);
      chk("hold_data", bus.mem_rsp_data_o, line);
      chk("hold_tag", bus.mem_rsp_tag_o, tg);
      chk("hold_req_ready", bus.mem_req_ready_o, 0);
      step();
    end
    chk("rsp_data", bus.mem_rsp_data_o, line);
    chk("rsp_tag", bus.mem_rsp_tag_o, tg);
    bus.mem_rsp_ready_i = 1'b1;
    step();
    bus.mem_rsp_ready_i = 1'b0;
    chk("rsp_valid_drop", bus.mem_rsp_valid_o, 0);
    chk("ready_after_rsp", bus.mem_req_ready_o, 1);
  endtask
  initial begin
    bus.mem_req_valid_i  = 1'b0;
    bus.mem_req_rw_i     = 1'b0;
    bus.mem_req_byteen_i = '0;
    bus.mem_req_addr_i   = '0;
    bus.mem_req_data_i   = '0;
    bus.mem_req_tag_i    = '0;
    bus.mem_rsp_ready_i  = 1'b0;
    bus.obi_gnt_i        = 1'b0;
    bus.obi_rvalid_i     = 1'b0;
    bus.obi_rdata_i      = '0;
    step();
    step();
    chk("rst_ready", bus.mem_req_ready_o, 1);
    chk("rst_rsp_valid", bus.mem_rsp_valid_o, 0);
    chk("rst_obi_req", bus.obi_req_o, 0);
    chk("rst_obi_addr", bus.obi_addr_o, 0);
    chk("rst_rsp_data", bus.mem_rsp_data_o, 0);
    chk("rst_rsp_tag", bus.mem_rsp_tag_o, 0);
    rst_n = 1'b1;
    step();
    do_read(28'h0000100, 8'h5A, 128'h00000044_00000033_00000022_00000011, 0, 0, 1'b0);
    bus.mem_req_valid_i  = 1'b1;
    bus.mem_req_rw_i     = 1'b1;
    bus.mem_req_addr_i   = 28'h0000200;
    bus.mem_req_byteen_i = 16'hFFFF;
    bus.mem_req_data_i   = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    bus.mem_req_tag_i    = 8'h33;
    step();
    bus.mem_req_valid_i = 1'b0;
    chk("wr_ready_busy", bus.mem_req_ready_o, 0);
    beat(32'h2000, 1'b1, 4'hF, 32'hA0A0A0A0, 32'h0, 0);
    beat(32'h2004, 1'b1, 4'hF, 32'hA1A1A1A1, 32'h0, 0);
    beat(32'h2008, 1'b1, 4'hF, 32'hA2A2A2A2, 32'h0, 0);
    chk("wr_ready_mid", bus.mem_req_ready_o, 0);
    beat(32'h200C, 1'b1, 4'hF, 32'hA3A3A3A3, 32'h0, 0);
    chk("wr_ready_done", bus.mem_req_ready_o, 1);
    chk("wr_no_rsp", bus.mem_rsp_valid_o, 0);
    chk("wr_req_idle", bus.obi_req_o, 0);
    bus.mem_req_valid_i  = 1'b1;
    bus.mem_req_addr_i   = 28'h0000300;
    bus.mem_req_byteen_i = 16'h0F00;
    bus.mem_req_data_i   = 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0;
    step();
    bus.mem_req_valid_i = 1'b0;
    beat(32'h3008, 1'b1, 4'hF, 32'hD2D2D2D2, 32'h0, 0);
    chk("sparse_ready", bus.mem_req_ready_o, 1);
    chk("sparse_req_idle", bus.obi_req_o, 0);
    bus.mem_req_valid_i  = 1'b1;
    bus.mem_req_byteen_i = 16'h0000;
    step();
    bus.mem_req_valid_i = 1'b0;
    chk("zero_be_req", bus.obi_req_o, 0);
    chk("zero_be_ready", bus.mem_req_ready_o, 1);
    step();
    chk("zero_be_req2", bus.obi_req_o, 0);
    do_read(28'h0000400, 8'hC3, 128'hCAFE0004_CAFE0003_CAFE0002_CAFE0001, 3, 5, 1'b0);
    bus.mem_req_valid_i = 1'b1;
    bus.mem_req_rw_i    = 1'b0;
    bus.mem_req_addr_i  = 28'h0000500;
    bus.mem_req_tag_i   = 8'h77;
    step();
    bus.mem_req_valid_i = 1'b0;
    beat(32'h5000, 1'b0, 4'hF, 32'h0, 32'h1, 0);
    beat(32'h5004, 1'b0, 4'hF, 32'h0, 32'h2, 0);
    chk("rst2_req", bus.obi_req_o, 1);
    chk("rst2_addr", bus.obi_addr_o, 32'h5008);
    bus.obi_gnt_i = 1'b1;
    step();
    bus.obi_gnt_i = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_ready", bus.mem_req_ready_o, 1);
    chk("midrst_req", bus.obi_req_o, 0);
    bus.obi_rvalid_i = 1'b1;
    bus.obi_rdata_i  = 32'hDEADBEEF;
    step();
    bus.obi_rvalid_i = 1'b0;
    chk("late_rvalid_ready", bus.mem_req_ready_o, 1);
    chk("late_rvalid_req", bus.obi_req_o, 0);
    chk("late_rvalid_rsp", bus.mem_rsp_valid_o, 0);
    do_read(28'h0000600, 8'h12, 128'h88888888_77777777_66666666_55555555, 0, 0, 1'b0);
    bus.obi_rvalid_i = 1'b1;
    bus.obi_rdata_i  = 32'hBAD1BAD1;
    step();
    bus.obi_rvalid_i = 1'b0;
    chk("spur_idle_ready", bus.mem_req_ready_o, 1);
    chk("spur_idle_req", bus.obi_req_o, 0);
    chk("spur_idle_rsp", bus.mem_rsp_valid_o, 0);
    do_read(28'hFFFFFFF, 8'hE1, 128'h0000000D_0000000C_0000000B_0000000A, 0, 1, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
